adder_accumulator: RTL and testbench
====================================

ADDER_ACCUMULATOR -- requirements
Module: adder_accumulator

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/sum width of the upstream adder.
REQ-002 SHALL have parameter ACC_WIDTH, default 16, accumulator width; ACC_WIDTH >= WIDTH+1.
REQ-003 SHALL have parameter BLOCK_LEN, default 4, samples per block; range 1..255.
REQ-004 clk  input  1  sole clock, all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  adder result present on sum_in/carry_in.
REQ-007 in_ready  output  1  block accepts a sample this cycle.
REQ-008 sum_in  input  WIDTH  adder sum_out.
REQ-009 carry_in  input  1  adder carry_out.
REQ-010 clear  input  1  synchronous abort of current block.
REQ-011 out_valid  output  1  block result available.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 acc_out  output  ACC_WIDTH  block total.
REQ-014 ovf_out  output  1  sticky overflow/saturation flag for the block.
REQ-015 blk_cnt  output  8  completed-block count, wraps 255->0.

Function
REQ-016 Sample value SHALL be the zero-extended WIDTH+1-bit {carry_in, sum_in}.
REQ-017 FSM SHALL have states ACCUM and HOLD; reset state ACCUM.
REQ-018 in_ready SHALL be 1 in ACCUM, 0 in HOLD, combinational from state only.
REQ-019 Sample SHALL be accepted only on in_valid && in_ready; acc += sample, sample counter +1, in the same edge.
REQ-020 On acceptance of the BLOCK_LEN-th sample, FSM SHALL go to HOLD next cycle with acc_out equal to the full block total (latency 1 cycle from last accept to out_valid).
REQ-021 In HOLD, out_valid=1 and acc_out/ovf_out SHALL be stable until out_valid && out_ready.
REQ-022 On out handshake, SHALL return to ACCUM, clear accumulator, sample counter and ovf, increment blk_cnt; next sample accepted no earlier than the following cycle.
REQ-023 Addition overflowing ACC_WIDTH SHALL set ovf (sticky for the block); value behaviour per Configuration.
REQ-024 clear=1 in ACCUM SHALL zero accumulator, counter and ovf; a simultaneous in_valid sample SHALL be discarded; blk_cnt unchanged.
REQ-025 clear=1 in HOLD SHALL be ignored (result not lost).
REQ-026 out_valid SHALL be 0 in ACCUM; acc_out SHALL show the running total in ACCUM.

Reset
REQ-027 rst_n low SHALL immediately force: state ACCUM, acc_out 0, ovf_out 0, out_valid 0, blk_cnt 0, sample counter 0.
REQ-028 Reset asserted mid-block or in HOLD SHALL discard partial/pending results; first accept after deassertion SHALL be sample 1 of a new block.

Configuration
REQ-029 Macro ADDER_ACC_SATURATE_EN defined: overflowing addition SHALL clamp acc to 2^ACC_WIDTH-1 and remain there for the block.
REQ-030 Macro undefined: overflowing addition SHALL wrap modulo 2^ACC_WIDTH; ovf_out set in both builds.

Verification
REQ-031 Defaults, samples {c,s}=(0,10),(0,20),(1,5),(0,255), out_ready=1 -> out_valid one cycle after 4th accept, acc_out=546, ovf_out=0, blk_cnt=1 after handshake.
REQ-032 out_ready=0 for 5 cycles in HOLD with in_valid=1 -> in_ready=0, acc_out stable, no samples consumed; accepts resume cycle after handshake.
REQ-033 ACC_WIDTH=9, samples 511 then 2 -> ovf_out=1; acc_out=511 with ADDER_ACC_SATURATE_EN, 1 without.
REQ-034 Two samples of 100, then clear with in_valid=1 (sample 7) -> acc_out=0, next 4 samples of 1 give acc_out=4.
REQ-035 rst_n pulsed low in HOLD -> out_valid=0, acc_out=0, blk_cnt=0 immediately, before next clk edge.
REQ-036 256 back-to-back blocks with out_ready=1 -> blk_cnt wraps to 0, no sample dropped.

Source files
------------

// File: rtl/adder_accumulator.sv
// Block accumulator for an upstream adder: sums BLOCK_LEN {carry,sum} samples and hands the total downstream.
// Build option: define ADDER_ACC_SATURATE_EN to clamp on overflow instead of wrapping.
module adder_accumulator #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned ACC_WIDTH = 16,
   parameter int unsigned BLOCK_LEN = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     sum_in,
   input  logic                 carry_in,
   input  logic                 clear,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [ACC_WIDTH-1:0] acc_out,
   output logic                 ovf_out,
   output logic [7:0]           blk_cnt
);

   localparam int unsigned SAMPLE_W = WIDTH + 1;
   localparam int unsigned SUM_W    = ACC_WIDTH + 1;
   localparam int unsigned CNT_W    = 8;
   localparam logic [CNT_W-1:0]     LAST_IDX = CNT_W'(BLOCK_LEN - 1);
   localparam logic [ACC_WIDTH-1:0] ACC_MAX  = '1;

   typedef enum logic {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } state_t;

   state_t               state;
   logic [CNT_W-1:0]     smp_cnt;
   logic [SAMPLE_W-1:0]  sample;
   logic [SUM_W-1:0]     sum_wide;
   logic                 add_ovf;
   logic [ACC_WIDTH-1:0] acc_next;

   assign sample   = {carry_in, sum_in};
   assign in_ready = (state == ACCUM);

   // One extra bit catches the carry out of the accumulator.
   assign sum_wide = {1'b0, acc_out} + SUM_W'(sample);
   assign add_ovf  = sum_wide[ACC_WIDTH];

   always_comb begin
      acc_next = sum_wide[ACC_WIDTH-1:0];
`ifdef ADDER_ACC_SATURATE_EN
      if (add_ovf) acc_next = ACC_MAX;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ACCUM;
         acc_out   <= '0;
         ovf_out   <= 1'b0;
         out_valid <= 1'b0;
         blk_cnt   <= '0;
         smp_cnt   <= '0;
      end else begin
         case (state)
            ACCUM: begin
               if (clear) begin
                  acc_out <= '0;
                  ovf_out <= 1'b0;
                  smp_cnt <= '0;
               end else if (in_valid) begin
                  acc_out <= acc_next;
                  ovf_out <= ovf_out | add_ovf;
                  if (smp_cnt == LAST_IDX) begin
                     smp_cnt   <= '0;
                     state     <= HOLD;
                     out_valid <= 1'b1;
                  end else begin
                     smp_cnt <= smp_cnt + 8'd1;
                  end
               end
            end
            HOLD: begin
               // clear is deliberately ignored here so a finished block is never lost.
               if (out_ready) begin
                  state     <= ACCUM;
                  out_valid <= 1'b0;
                  acc_out   <= '0;
                  ovf_out   <= 1'b0;
                  smp_cnt   <= '0;
                  blk_cnt   <= blk_cnt + 8'd1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_adder_accumulator.sv
// Bench for adder_accumulator: two instances (default and 9-bit/2-sample) against a queue-based block model.
module tb_adder_accumulator;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       iv[2], cr[2], clr[2], ordy[2];
   logic [7:0] s[2];
   logic       ir[2], ov[2], of[2];
   logic [7:0] blk[2];
   logic [15:0] acc0;
   logic [8:0]  acc1;

   adder_accumulator #(.WIDTH(8), .ACC_WIDTH(16), .BLOCK_LEN(4)) dut0 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .sum_in(s[0]),
      .carry_in(cr[0]), .clear(clr[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
      .acc_out(acc0), .ovf_out(of[0]), .blk_cnt(blk[0]));

   adder_accumulator #(.WIDTH(8), .ACC_WIDTH(9), .BLOCK_LEN(2)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .sum_in(s[1]),
      .carry_in(cr[1]), .clear(clr[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
      .acc_out(acc1), .ovf_out(of[1]), .blk_cnt(blk[1]));

   typedef struct {
      longint acc;
      bit     ovf;
   } exp_t;

   exp_t   q0[$];
   exp_t   q1[$];
   int     bl[2] = '{4, 2};
   int     aw[2] = '{16, 9};
   longint m_acc[2];
   bit     m_ovf[2];
   int     m_cnt[2];
   bit     m_pend[2];
   int     m_blk[2];
   int     n_tests = 0;
   int     n_fail  = 0;

   task automatic check(input string name, input longint act, input longint exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_acc[i] = 0; m_ovf[i] = 1'b0; m_cnt[i] = 0; m_pend[i] = 1'b0; m_blk[i] = 0;
      end
      q0.delete();
      q1.delete();
   endtask

   // Block-level reference: a block is a list of BLOCK_LEN sums; its result waits until taken.
   task automatic model_step(input int i);
      longint lim = longint'(1) << aw[i];
      longint tot;
      exp_t   e;
      if (!m_pend[i]) begin
         if (clr[i]) begin
            m_acc[i] = 0; m_ovf[i] = 1'b0; m_cnt[i] = 0;
         end else if (iv[i]) begin
            tot = m_acc[i] + longint'({cr[i], s[i]});
            if (tot >= lim) begin
               m_ovf[i] = 1'b1;
`ifdef ADDER_ACC_SATURATE_EN
               tot = lim - 1;
`else
               tot = tot % lim;
`endif
            end
            m_acc[i] = tot;
            m_cnt[i]++;
            if (m_cnt[i] == bl[i]) begin
               m_pend[i] = 1'b1;
               e.acc = m_acc[i];
               e.ovf = m_ovf[i];
               if (i == 0) q0.push_back(e); else q1.push_back(e);
            end
         end
      end else if (ordy[i]) begin
         m_pend[i] = 1'b0;
         m_acc[i] = 0; m_ovf[i] = 1'b0; m_cnt[i] = 0;
         m_blk[i] = (m_blk[i] + 1) % 256;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst_n) begin
         model_step(0);
         model_step(1);
      end
      #1;
   endtask

   task automatic send(input int i, input logic c, input logic [7:0] v);
      iv[i] = 1'b1; cr[i] = c; s[i] = v;
      tick();
   endtask

   task automatic randomize_inputs(input int i, input int p_valid, input int p_clear, input int p_ready);
      iv[i]   = ($urandom_range(0, 99) < p_valid);
      clr[i]  = ($urandom_range(0, 99) < p_clear);
      ordy[i] = ($urandom_range(0, 99) < p_ready);
      cr[i]   = 1'($urandom_range(0, 1));
      s[i]    = 8'($urandom_range(0, 255));
   endtask

   // Monitor: compares handshake signals, running total and queued block results every cycle.
   always @(negedge clk) begin
      if (rst_n) begin
         for (int i = 0; i < 2; i++) begin
            longint a;
            exp_t   e;
            a = (i == 0) ? longint'(acc0) : longint'(acc1);
            check($sformatf("in_ready%0d", i), longint'(ir[i]), longint'(!m_pend[i]));
            check($sformatf("out_valid%0d", i), longint'(ov[i]), longint'(m_pend[i]));
            check($sformatf("blk_cnt%0d", i), longint'(blk[i]), longint'(m_blk[i]));
            if (ov[i]) begin
               if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
                  check($sformatf("unexpected_result%0d", i), 1, 0);
               end else begin
                  e = (i == 0) ? q0[0] : q1[0];
                  check($sformatf("result_acc%0d", i), a, e.acc);
                  check($sformatf("result_ovf%0d", i), longint'(of[i]), longint'(e.ovf));
                  if (ordy[i]) begin
                     if (i == 0) void'(q0.pop_front()); else void'(q1.pop_front());
                  end
               end
            end else begin
               check($sformatf("running_acc%0d", i), a, m_acc[i]);
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
         iv[i] = 1'b0; cr[i] = 1'b0; s[i] = 8'd0; clr[i] = 1'b0; ordy[i] = 1'b0;
      end
      model_reset();
      #1 rst_n = 1'b0;
      #1;
      check("rst_out_valid0", longint'(ov[0]), 0);
      check("rst_acc0", longint'(acc0), 0);
      check("rst_blk0", longint'(blk[0]), 0);
      check("rst_in_ready0", longint'(ir[0]), 1);
      check("rst_ovf1", longint'(of[1]), 0);
      check("rst_acc1", longint'(acc1), 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // Reference block: 10 + 20 + 261 + 255.
      ordy[0] = 1'b1;
      send(0, 1'b0, 8'd10);
      send(0, 1'b0, 8'd20);
      send(0, 1'b1, 8'd5);
      send(0, 1'b0, 8'd255);
      iv[0] = 1'b0;
      @(negedge clk);
      check("blk546_valid", longint'(ov[0]), 1);
      check("blk546_acc", longint'(acc0), 546);
      check("blk546_ovf", longint'(of[0]), 0);
      tick();
      @(negedge clk);
      check("blk546_count", longint'(blk[0]), 1);

      // 511 + 2 on a 9-bit accumulator.
      ordy[1] = 1'b0;
      send(1, 1'b1, 8'd255);
      send(1, 1'b0, 8'd2);
      iv[1] = 1'b0;
      @(negedge clk);
      check("ovf9_flag", longint'(of[1]), 1);
`ifdef ADDER_ACC_SATURATE_EN
      check("ovf9_acc", longint'(acc1), 511);
`else
      check("ovf9_acc", longint'(acc1), 1);
`endif
      ordy[1] = 1'b1;
      tick();
      ordy[1] = 1'b0;

      // Back-pressure in HOLD with a sample waiting.
      ordy[0] = 1'b0;
      for (int k = 0; k < 4; k++) send(0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
      iv[0] = 1'b1; cr[0] = 1'b0; s[0] = 8'd33;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("hold_in_ready", longint'(ir[0]), 0);
         tick();
      end
      ordy[0] = 1'b1;
      tick();
      ordy[0] = 1'b0;
      tick();
      iv[0] = 1'b0;
      @(negedge clk);
      check("resume_first_sample", longint'(acc0), 33);

      // Abort with a coincident sample, then a fresh block of ones.
      clr[0] = 1'b1;
      tick();
      clr[0] = 1'b0;
      send(0, 1'b0, 8'd100);
      send(0, 1'b0, 8'd100);
      clr[0] = 1'b1; iv[0] = 1'b1; s[0] = 8'd7;
      tick();
      clr[0] = 1'b0; iv[0] = 1'b0;
      @(negedge clk);
      check("clear_acc", longint'(acc0), 0);
      ordy[0] = 1'b1;
      for (int k = 0; k < 4; k++) send(0, 1'b0, 8'd1);
      iv[0] = 1'b0;
      @(negedge clk);
      check("after_clear_acc", longint'(acc0), 4);
      tick();

      // Back-to-back blocks long enough to wrap blk_cnt.
      for (int k = 0; k < 1320; k++) begin
         for (int i = 0; i < 2; i++) randomize_inputs(i, 100, 0, 100);
         tick();
      end

      // Random traffic with stalls, aborts and gaps.
      for (int k = 0; k < 3000; k++) begin
         for (int i = 0; i < 2; i++) randomize_inputs(i, 75, 5, 60);
         tick();
      end

      // Reset while a result is pending.
      clr[0] = 1'b0; ordy[0] = 1'b0; iv[0] = 1'b1;
      iv[1] = 1'b0;
      for (int k = 0; k < 20 && !m_pend[0]; k++) tick();
      check("reached_hold", longint'(m_pend[0]), 1);
      rst_n = 1'b0;
      #1;
      check("async_rst_valid", longint'(ov[0]), 0);
      check("async_rst_acc", longint'(acc0), 0);
      check("async_rst_blk", longint'(blk[0]), 0);
      check("async_rst_ready", longint'(ir[0]), 1);
      model_reset();
      #1 rst_n = 1'b1;

      for (int k = 0; k < 300; k++) begin
         for (int i = 0; i < 2; i++) randomize_inputs(i, 70, 5, 60);
         tick();
      end

      for (int i = 0; i < 2; i++) begin
         iv[i] = 1'b0; clr[i] = 1'b0; ordy[i] = 1'b1;
      end
      repeat (4) tick();
      @(negedge clk);
      check("drain_q0", longint'(q0.size()), 0);
      check("drain_q1", longint'(q1.size()), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
